// File: rtl/fpu_pkg.sv
// Shared FP helpers for the divider completion path: flag bit positions,
// canonical single-precision constants and an operand classifier.
package fpu_pkg;

    // Bit positions inside a RISC-V fflags vector {NV,DZ,OF,UF,NX}
    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    localparam logic [31:0] QNAN = 32'h7fc00000;
    localparam logic [31:0] INF  = 32'h7f800000;
    localparam logic [31:0] MAX  = 32'h7f7fffff;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic denorm;
    } fp_class_t;

    // Classify the magnitude (sign excluded) of a single-precision operand.
    // Denormals are deliberately not reported as zero.
    function automatic fp_class_t fp_class(input logic [30:0] mag);
        fp_class_t c;
        c.zero   = (mag[30:23] == 8'h00) && (mag[22:0] == 23'd0);
        c.inf    = (mag[30:23] == 8'hff) && (mag[22:0] == 23'd0);
        c.nan    = (mag[30:23] == 8'hff) && (mag[22:0] != 23'd0);
        c.denorm = (mag[30:23] == 8'h00) && (mag[22:0] != 23'd0);
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Generic DEPTH-entry FIFO with combinational head read. A push into a full
// FIFO without a same-cycle pop is dropped and reported on overflow.
module sync_fifo_ptr #(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int W     = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;
    assign rdata    = mem[rd_ptr];

    // Entry storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fdiv_wb_buffer.sv
// Completion stage for the iterative FP divider: tags the in-flight division,
// captures its quotient with fflags, and queues results for the FP write port.
module fdiv_wb_buffer
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        issue,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic        div_done,
    input  logic [31:0] div_s,
    input  logic        flush,
    input  logic        wb_ready,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_flags,
    output logic        issue_stall,
    output logic        err_overflow
);

    localparam int ENT_W = 5 + 32 + 5;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [4:0] tag_rd;
    logic       tag_a_zero, tag_a_inf, tag_a_nan;
    logic       tag_b_zero, tag_b_inf, tag_b_nan;

    fp_class_t  a_cls;
    fp_class_t  b_cls;
    logic       inflight;
    logic       push;
    logic       pop;
    logic [4:0] flags;
    logic       nv, dz;

    logic [ENT_W-1:0] fifo_wdata;
    logic [ENT_W-1:0] fifo_rdata;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_overflow;
    logic [PTR_W+1:0] reserved;

    // Sign bits and denormal status do not affect any flag in this revision
    logic unused_bits;
    assign unused_bits = &{1'b0, issue_a[31], issue_b[31], a_cls.denorm,
                           b_cls.denorm, fifo_full};

    assign a_cls    = fp_class(issue_a[30:0]);
    assign b_cls    = fp_class(issue_b[30:0]);
    assign inflight = (state == BUSY);
    assign push     = inflight & div_done & ~flush;
    assign pop      = wb_valid & wb_ready;

    // Flags come from the tag of the division that is completing now
    always_comb begin
        flags           = '0;
        nv              = tag_a_nan | tag_b_nan | (tag_a_zero & tag_b_zero)
                        | (tag_a_inf & tag_b_inf);
        dz              = tag_b_zero & ~tag_a_zero & ~tag_a_nan & ~tag_a_inf;
        flags[FFLAG_NV] = nv;
        flags[FFLAG_DZ] = dz;
        flags[FFLAG_OF] = ((div_s[30:0] == INF[30:0]) || (div_s[30:0] == MAX[30:0]))
                        & ~nv & ~dz & ~tag_a_inf;
        flags[FFLAG_UF] = 1'b0;
        flags[FFLAG_NX] = 1'b0;
    end

    assign fifo_wdata = {tag_rd, div_s, flags};

    // Tag FSM: one division in flight; a completion may coincide with the
    // next issue, in which case the old tag is used and then replaced
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            tag_rd     <= '0;
            tag_a_zero <= 1'b0;
            tag_a_inf  <= 1'b0;
            tag_a_nan  <= 1'b0;
            tag_b_zero <= 1'b0;
            tag_b_inf  <= 1'b0;
            tag_b_nan  <= 1'b0;
        end else begin
            if (issue) begin
                tag_rd     <= issue_rd;
                tag_a_zero <= a_cls.zero;
                tag_a_inf  <= a_cls.inf;
                tag_a_nan  <= a_cls.nan;
                tag_b_zero <= b_cls.zero;
                tag_b_inf  <= b_cls.inf;
                tag_b_nan  <= b_cls.nan;
            end
            case (state)
                IDLE: if (issue) state <= BUSY;
                BUSY: begin
                    if (flush)                  state <= IDLE;
                    else if (div_done && !issue) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky record of a result lost to a full queue
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            err_overflow <= 1'b0;
        end else if (fifo_overflow) begin
            err_overflow <= 1'b1;
        end
    end

    sync_fifo_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (ENT_W)
    ) u_fifo (
        .clk      (clk),
        .clrn     (clrn),
        .push     (push),
        .pop      (pop),
        .wdata    (fifo_wdata),
        .rdata    (fifo_rdata),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .overflow (fifo_overflow)
    );

    // Head fields read as zero whenever nothing is queued
    assign wb_valid = ~fifo_empty;
    assign {wb_rd, wb_data, wb_flags} = wb_valid ? fifo_rdata : '0;

    // Every in-flight division holds a reserved slot in the queue
    assign reserved    = {1'b0, fifo_count} + {{(PTR_W+1){1'b0}}, inflight};
    assign issue_stall = inflight | (reserved >= (PTR_W+2)'(DEPTH));

endmodule

// File: tb/tb_fdiv_wb_buffer.sv
// Randomized bench for fdiv_wb_buffer with a queue-based reference model.
module tb_fdiv_wb_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        clrn;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [31:0] issue_a, issue_b;
    logic        div_done;
    logic [31:0] div_s;
    logic        flush;
    logic        wb_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  wb_flags;
    logic        issue_stall;
    logic        err_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    fdiv_wb_buffer #(.DEPTH(DEPTH), .PTR_W(1)) dut (
        .clk(clk), .clrn(clrn), .issue(issue), .issue_rd(issue_rd),
        .issue_a(issue_a), .issue_b(issue_b), .div_done(div_done),
        .div_s(div_s), .flush(flush), .wb_ready(wb_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_flags(wb_flags), .issue_stall(issue_stall),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flags;
    } ent_t;

    ent_t        mq[$];
    bit          m_busy = 0;
    bit          m_err  = 0;
    logic [4:0]  m_rd;
    logic [31:0] m_a, m_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // IEEE-754 division exception rules, from the operands' meaning
    function automatic logic [4:0] exp_flags(logic [31:0] a, logic [31:0] b, logic [31:0] s);
        bit an, ai, az, bn, bi, bz, nv, dz, of;
        an = (a[30:23] == 8'hff) && (a[22:0] != 0);
        ai = (a[30:23] == 8'hff) && (a[22:0] == 0);
        az = (a[30:0] == 0);
        bn = (b[30:23] == 8'hff) && (b[22:0] != 0);
        bi = (b[30:23] == 8'hff) && (b[22:0] == 0);
        bz = (b[30:0] == 0);
        nv = an || bn || (az && bz) || (ai && bi);
        dz = bz && !az && !an && !ai;
        of = (s[30:0] == 31'h7f800000 || s[30:0] == 31'h7f7fffff) && !nv && !dz && !ai;
        return {nv, dz, of, 2'b00};
    endfunction

    function automatic bit m_stall();
        return m_busy || ((mq.size() + int'(m_busy)) >= DEPTH);
    endfunction

    // Reference model advances on each clock edge
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mq.delete();
            m_busy = 0;
            m_err  = 0;
        end else begin
            bit   do_pop, do_push;
            ent_t e;
            if (issue && m_stall()) chk("issue_while_stalled", 32'd1, 32'd0);
            do_pop  = (mq.size() != 0) && wb_ready;
            do_push = m_busy && div_done && !flush;
            e.rd    = m_rd;
            e.data  = div_s;
            e.flags = exp_flags(m_a, m_b, div_s);
            if (do_push && mq.size() >= DEPTH && !do_pop) m_err = 1;
            if (do_pop) void'(mq.pop_front());
            if (do_push && !(mq.size() >= DEPTH)) mq.push_back(e);
            if (m_busy) begin
                if (flush)         m_busy = 0;
                else if (div_done) m_busy = issue;
            end else begin
                m_busy = issue;
            end
            if (issue) begin
                m_rd = issue_rd; m_a = issue_a; m_b = issue_b;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (clrn) begin
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, mq[0].rd});
                chk("wb_data", wb_data, mq[0].data);
                chk("wb_flags", {27'd0, wb_flags}, {27'd0, mq[0].flags});
            end else begin
                chk("wb_idle_fields", {wb_rd, wb_flags}, 32'd0);
            end
            chk("issue_stall", {31'd0, issue_stall}, {31'd0, m_stall()});
            chk("err_overflow", {31'd0, err_overflow}, {31'd0, m_err});
        end
    end

    task automatic drive(input bit iss, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input bit dn, input logic [31:0] s,
                         input bit fl, input bit rdy);
        issue = iss; issue_rd = rd; issue_a = a; issue_b = b;
        div_done = dn; div_s = s; flush = fl; wb_ready = rdy;
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        drive(0, 5'd0, 32'd0, 32'd0, 0, 32'd0, 0, rdy);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom % 10)
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7f800000;
            3: return 32'hff800000;
            4: return 32'h7fc00000;
            5: return 32'h7f800001;
            6: return 32'h00000001;
            7: return 32'h3f800000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_res();
        case ($urandom % 8)
            0: return 32'h7f800000;
            1: return 32'h7f7fffff;
            2: return 32'hff800000;
            3: return 32'hff7fffff;
            4: return 32'h7fc00000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        clrn = 0;
        issue = 0; issue_rd = 0; issue_a = 0; issue_b = 0;
        div_done = 0; div_s = 0; flush = 0; wb_ready = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_stall", {31'd0, issue_stall}, 32'd0);
        chk("rst_err", {31'd0, err_overflow}, 32'd0);
        chk("rst_fields", {wb_rd, wb_flags} ^ wb_data, 32'd0);
        clrn = 1;
        idle(1);

        // Basic 3.0 / 2.0
        drive(1, 5'd3, 32'h40400000, 32'h40000000, 0, 0, 0, 1);
        chk("basic_stall_busy", {31'd0, issue_stall}, 32'd1);
        drive(0, 0, 0, 0, 1, 32'h3fc00000, 0, 1);
        chk("basic_valid", {31'd0, wb_valid}, 32'd1);
        chk("basic_rd", {27'd0, wb_rd}, 32'd3);
        chk("basic_data", wb_data, 32'h3fc00000);
        chk("basic_flags", {27'd0, wb_flags}, 32'd0);
        idle(1);
        chk("basic_drained", {31'd0, wb_valid}, 32'd0);

        // Divide by zero, then 0/0
        drive(1, 5'd9, 32'h3f800000, 32'h00000000, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 32'h7f800000, 0, 1);
        chk("dz_flags", {27'd0, wb_flags}, 32'h08);
        idle(1);
        drive(1, 5'd10, 32'h00000000, 32'h00000000, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 32'h7fc00000, 0, 1);
        chk("nv_flags", {27'd0, wb_flags}, 32'h10);
        idle(1);

        // Overflow flag
        drive(1, 5'd11, 32'h7f000000, 32'h3e800000, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 32'h7f800000, 0, 1);
        chk("of_flags", {27'd0, wb_flags}, 32'h04);
        idle(1);

        // Backpressure: two queued, third issue blocked, in-order drain
        drive(1, 5'd1, 32'h3f800000, 32'h40000000, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h3f000000, 0, 0);
        chk("bp_stall_one", {31'd0, issue_stall}, 32'd0);
        drive(1, 5'd2, 32'h7fc00000, 32'h3f800000, 0, 0, 0, 0);
        chk("bp_stall_reserved", {31'd0, issue_stall}, 32'd1);
        drive(0, 0, 0, 0, 1, 32'h7fc00000, 0, 0);
        idle(0);
        idle(0);
        chk("bp_stall_full", {31'd0, issue_stall}, 32'd1);
        chk("bp_head_rd", {27'd0, wb_rd}, 32'd1);
        chk("bp_head_data", wb_data, 32'h3f000000);
        idle(1);
        chk("bp_second_rd", {27'd0, wb_rd}, 32'd2);
        chk("bp_second_flags", {27'd0, wb_flags}, 32'h10);
        idle(1);
        chk("bp_empty", {31'd0, wb_valid}, 32'd0);

        // Flush coinciding with completion; older entry survives
        drive(1, 5'd5, 32'h40400000, 32'h40000000, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h3fc00000, 0, 0);
        drive(1, 5'd7, 32'h40400000, 32'h40000000, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h12345678, 1, 0);
        chk("fl_stall_drop", {31'd0, issue_stall}, 32'd0);
        chk("fl_old_rd", {27'd0, wb_rd}, 32'd5);
        idle(1);
        chk("fl_drained", {31'd0, wb_valid}, 32'd0);

        // Asynchronous reset while busy with one queued entry
        drive(1, 5'd4, 32'h40400000, 32'h40000000, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h3fc00000, 0, 0);
        drive(1, 5'd6, 32'h40400000, 32'h40000000, 0, 0, 0, 0);
        #1 clrn = 0;
        #1;
        chk("arst_valid", {31'd0, wb_valid}, 32'd0);
        chk("arst_stall", {31'd0, issue_stall}, 32'd0);
        chk("arst_err", {31'd0, err_overflow}, 32'd0);
        @(negedge clk);
        clrn = 1;
        drive(0, 0, 0, 0, 1, 32'h3fc00000, 0, 0);
        chk("arst_done_ignored", {31'd0, wb_valid}, 32'd0);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          iss;
            logic [31:0] a, b, s;
            iss = !m_stall() && ($urandom % 3 == 0);
            a = pick_op();
            b = pick_op();
            s = pick_res();
            drive(iss, 5'($urandom), a, b, ($urandom % 4 == 0), s,
                  ($urandom % 16 == 0), ($urandom % 4 != 0));
        end
        repeat (4) idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
